reg_file_mp: RTL and testbench

//   Parametrised multi-port register file, the next generation of the processor register file.
//   - Configurable data width, depth and read-port count.
//   - Clocked write; registered reads with per-port enable.
//   - Write-to-read bypass and per-port zero flag for branch decisions.
//   - Hardware clear sequencer; optional hardwired zero register.

---
 rtl/reg_file_mp_if.sv | 28 ++
 rtl/reg_file_mp.sv | 112 +++++++++++
 tb/tb_reg_file_mp.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: write port, read ports and status.
// The master side drives requests; the slave side (the register file) returns read data and status.
interface reg_file_mp_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic                       clr_req;
  logic                       wr_en;
  logic [ADDR_W-1:0]          wr_addr;
  logic [DATA_W-1:0]          wr_data;
  logic [NUM_RD-1:0]          rd_en;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic [NUM_RD-1:0]          rd_valid;
  logic [NUM_RD-1:0]          rd_zero;
  logic                       busy;

  modport master (
    output clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, rd_zero, busy
  );

  modport slave (
    input  clr_req, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, rd_zero, busy
  );
endinterface

// File: rtl/reg_file_mp.sv
// Parametrised multi-port register file with registered reads, write-to-read bypass,
// per-port zero flags, a hardware clear sequencer and an optional hardwired zero register.
module reg_file_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic           clk,
  input  logic           reset,
  reg_file_mp_if.slave   bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] LAST_ENTRY = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {
    CLEAR,
    READY
  } state_t;

  state_t                          state;
  logic [ADDR_W:0]                 clr_cnt;
  logic [DATA_W-1:0]               mem [DEPTH];

  logic [NUM_RD-1:0][ADDR_W-1:0]   ra;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_q;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_next;
  logic [NUM_RD-1:0]               valid_q;
  logic [NUM_RD-1:0]               zero_flags;
  logic                            wr_zero_hit;
  logic                            wr_ok;

  assign ra = bus.rd_addr;

  // A write is committed only in READY, not on the cycle a clear starts, and never to a hardwired R0.
  assign wr_zero_hit = (ZERO_REG != 0) && (bus.wr_addr == '0);
  assign wr_ok       = (state == READY) && bus.wr_en && !bus.clr_req && !wr_zero_hit;

  // Storage carries no reset: the clear sequencer zeroes it after every reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_cnt[ADDR_W-1:0]] <= '0;
      end else if (wr_ok) begin
        mem[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Bypass takes priority over storage; a hardwired R0 overrides both.
  always_comb begin
    rd_next = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_next[k] = mem[ra[k]];
      if (wr_ok && (bus.wr_addr == ra[k])) begin
        rd_next[k] = bus.wr_data;
      end
      if ((ZERO_REG != 0) && (ra[k] == '0)) begin
        rd_next[k] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      rd_q    <= '0;
      valid_q <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          valid_q <= '0;
          if (clr_cnt == LAST_ENTRY) begin
            state <= READY;
          end
        end
        READY: begin
          if (bus.clr_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
          for (int unsigned k = 0; k < NUM_RD; k++) begin
            if (bus.rd_en[k]) begin
              rd_q[k] <= rd_next[k];
            end
          end
          valid_q <= bus.rd_en;
        end
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    zero_flags = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      zero_flags[k] = ~|rd_q[k];
    end
  end

  assign bus.rd_data  = rd_q;
  assign bus.rd_valid = valid_q;
  assign bus.rd_zero  = zero_flags;
  assign bus.busy     = (state == CLEAR);

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: one instance with a normal R0, one with a hardwired R0.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [15:0] qa0[$];
  logic [15:0] qa1[$];
  logic [15:0] qb0[$];
  logic [15:0] qb1[$];

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) a_if ();
  reg_file_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2)) b_if ();

  reg_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(0)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if.slave)
  );
  reg_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (a_if.busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  // Monitor: every valid read beat must match the oldest expected value for that port.
  always @(negedge clk) begin
    if (a_if.rd_valid[0] === 1'b1) begin
      if (qa0.size() == 0) chk("a_p0_unexpected_valid", 32'd1, 32'd0);
      else begin
        logic [15:0] e;
        e = qa0.pop_front();
        chk("a_p0_data", {16'd0, a_if.rd_data[15:0]}, {16'd0, e});
        chk("a_p0_zero", {31'd0, a_if.rd_zero[0]}, {31'd0, e == 16'd0});
      end
    end
    if (a_if.rd_valid[1] === 1'b1) begin
      if (qa1.size() == 0) chk("a_p1_unexpected_valid", 32'd1, 32'd0);
      else begin
        logic [15:0] e;
        e = qa1.pop_front();
        chk("a_p1_data", {16'd0, a_if.rd_data[31:16]}, {16'd0, e});
        chk("a_p1_zero", {31'd0, a_if.rd_zero[1]}, {31'd0, e == 16'd0});
      end
    end
    if (b_if.rd_valid[0] === 1'b1) begin
      if (qb0.size() == 0) chk("b_p0_unexpected_valid", 32'd1, 32'd0);
      else begin
        logic [15:0] e;
        e = qb0.pop_front();
        chk("b_p0_data", {16'd0, b_if.rd_data[15:0]}, {16'd0, e});
        chk("b_p0_zero", {31'd0, b_if.rd_zero[0]}, {31'd0, e == 16'd0});
      end
    end
    if (b_if.rd_valid[1] === 1'b1) begin
      if (qb1.size() == 0) chk("b_p1_unexpected_valid", 32'd1, 32'd0);
      else begin
        logic [15:0] e;
        e = qb1.pop_front();
        chk("b_p1_data", {16'd0, b_if.rd_data[31:16]}, {16'd0, e});
        chk("b_p1_zero", {31'd0, b_if.rd_zero[1]}, {31'd0, e == 16'd0});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1;
    a_if.clr_req = 1'b0; a_if.wr_en = 1'b0; a_if.wr_addr = '0; a_if.wr_data = '0;
    a_if.rd_en = '0; a_if.rd_addr = '0;
    b_if.clr_req = 1'b0; b_if.wr_en = 1'b0; b_if.wr_addr = '0; b_if.wr_data = '0;
    b_if.rd_en = '0; b_if.rd_addr = '0;

    // Reset, then the power-up clear runs for DEPTH cycles
    step();
    reset = 1'b0;
    chk("reset_rd_data", a_if.rd_data, 32'h0);
    chk("reset_rd_zero", {30'd0, a_if.rd_zero}, 32'd3);
    chk("reset_rd_valid", {30'd0, a_if.rd_valid}, 32'd0);
    chk("reset_busy", {31'd0, a_if.busy}, 32'd1);
    wait_busy(n);
    chk("busy_cycles_after_reset", n, 32'd16);
    chk("idle_rd_data", a_if.rd_data, 32'h0);
    chk("idle_rd_zero", {30'd0, a_if.rd_zero}, 32'd3);
    chk("b_ready_after_reset", {31'd0, b_if.busy}, 32'd0);

    // Write then read on port 0
    a_if.wr_en = 1'b1; a_if.wr_addr = 4'd5; a_if.wr_data = 16'h00A3;
    step();
    a_if.wr_en = 1'b0; a_if.rd_en = 2'b01; a_if.rd_addr = {4'd0, 4'd5};
    qa0.push_back(16'h00A3);
    step();
    a_if.rd_en = 2'b00;

    // Same-cycle write and dual-port read of the same address
    a_if.wr_en = 1'b1; a_if.wr_addr = 4'd7; a_if.wr_data = 16'h1234;
    a_if.rd_en = 2'b11; a_if.rd_addr = {4'd7, 4'd7};
    qa0.push_back(16'h1234); qa1.push_back(16'h1234);
    step();
    a_if.wr_en = 1'b0;
    a_if.rd_en = 2'b11; a_if.rd_addr = {4'd5, 4'd7};
    qa0.push_back(16'h1234); qa1.push_back(16'h00A3);
    step();
    a_if.rd_en = 2'b00;

    // Hardwired R0: stored write and bypass both read back as zero
    b_if.wr_en = 1'b1; b_if.wr_addr = 4'd0; b_if.wr_data = 16'hFFFF;
    step();
    b_if.wr_en = 1'b0; b_if.rd_en = 2'b10; b_if.rd_addr = {4'd0, 4'd0};
    qb1.push_back(16'h0000);
    step();
    b_if.wr_en = 1'b1; b_if.wr_addr = 4'd0; b_if.wr_data = 16'hFFFF;
    b_if.rd_en = 2'b10; b_if.rd_addr = {4'd0, 4'd0};
    qb1.push_back(16'h0000);
    step();
    b_if.wr_en = 1'b1; b_if.wr_addr = 4'd5; b_if.wr_data = 16'h0005;
    b_if.rd_en = 2'b10; b_if.rd_addr = {4'd5, 4'd0};
    qb1.push_back(16'h0005);
    step();
    b_if.wr_en = 1'b0; b_if.rd_en = 2'b00;

    // Clear request drops the same-cycle write and wipes all entries
    a_if.wr_en = 1'b1; a_if.wr_addr = 4'd3; a_if.wr_data = 16'h0009;
    step();
    a_if.wr_en = 1'b0; a_if.rd_en = 2'b01; a_if.rd_addr = {4'd0, 4'd3};
    qa0.push_back(16'h0009);
    step();
    a_if.rd_en = 2'b00;
    a_if.wr_en = 1'b1; a_if.wr_addr = 4'd4; a_if.wr_data = 16'h0007; a_if.clr_req = 1'b1;
    step();
    a_if.wr_en = 1'b0; a_if.clr_req = 1'b0;
    wait_busy(n);
    chk("busy_cycles_after_clr_req", n, 32'd16);
    a_if.rd_en = 2'b11; a_if.rd_addr = {4'd4, 4'd3};
    qa0.push_back(16'h0000); qa1.push_back(16'h0000);
    step();
    a_if.rd_en = 2'b00;

    // Reset in the middle of a clear restarts the sequence; reads while busy are ignored
    a_if.wr_en = 1'b1; a_if.wr_addr = 4'd2; a_if.wr_data = 16'h55AA;
    step();
    a_if.wr_en = 1'b0; a_if.rd_en = 2'b11; a_if.rd_addr = {4'd2, 4'd2};
    qa0.push_back(16'h55AA); qa1.push_back(16'h55AA);
    step();
    a_if.rd_en = 2'b00; a_if.clr_req = 1'b1;
    step();
    a_if.clr_req = 1'b0;
    chk("busy_on_clr_req", {31'd0, a_if.busy}, 32'd1);
    a_if.rd_en = 2'b11; a_if.rd_addr = {4'd2, 4'd2};
    step();
    chk("busy_read_valid", {30'd0, a_if.rd_valid}, 32'd0);
    chk("busy_read_hold", a_if.rd_data, 32'h55AA55AA);
    a_if.rd_en = 2'b00;
    repeat (5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("busy_after_mid_reset", {31'd0, a_if.busy}, 32'd1);
    a_if.rd_en = 2'b11; a_if.rd_addr = {4'd2, 4'd2};
    step();
    chk("busy_read_valid_after_reset", {30'd0, a_if.rd_valid}, 32'd0);
    chk("busy_read_hold_after_reset", a_if.rd_data, 32'h0);
    a_if.rd_en = 2'b00;
    wait_busy(n);
    chk("busy_cycles_after_mid_reset", 1 + n, 32'd16);
    a_if.rd_en = 2'b01; a_if.rd_addr = {4'd0, 4'd2};
    qa0.push_back(16'h0000);
    step();
    a_if.rd_en = 2'b00;

    repeat (3) step();
    chk("scoreboard_drained", qa0.size() + qa1.size() + qb0.size() + qb1.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
